// File: rtl/detector_pkg.sv
// Shared types and Q-format constants for the symbol detector output stage.
package detector_pkg;

  localparam int DET_N  = 32;
  localparam int DET_Q  = 22;
  localparam int SEXT_W = 128;

  localparam logic [DET_N-1:0] ONE_Q   = DET_N'(1) << DET_Q;
  localparam logic [DET_N-1:0] MAX_POS = {1'b0, {(DET_N-1){1'b1}}};
  localparam logic [DET_N-1:0] MIN_NEG = {1'b1, {(DET_N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_FILL   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // True when bits v[hi:lo] are not all equal, i.e. the value does not fit
  // after dropping bits above lo.
  function automatic logic sext_ovr(input logic [SEXT_W-1:0] v, input int lo, input int hi);
    logic ovr;
    ovr = 1'b0;
    for (int i = 1; i < SEXT_W; i++)
      if (i > lo && i <= hi && v[i] != v[i-1]) ovr = 1'b1;
    return ovr;
  endfunction

endpackage

// File: rtl/recip_serial_div.sv
// Bit-serial restoring divider producing 2^(2Q)/divisor in Q format,
// one quotient bit per cycle, saturating to MAX on overflow or divisor <= 0.
module recip_serial_div #(
  parameter int N = 32,
  parameter int Q = 22
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         ovr
);

  localparam logic [2*N-1:0] DVD     = (2*N)'(1) << (2*Q);
  localparam logic [N-1:0]   DVD_HI  = DVD[2*N-1:N];
  localparam logic [N-1:0]   DVD_LO  = DVD[N-1:0];
  localparam int             CW      = $clog2(N);
  localparam logic [CW-1:0]  CNT_END = CW'(N-1);
  localparam logic [N-1:0]   Q_MAX   = {1'b0, {(N-1){1'b1}}};

  logic [N-1:0]  dvs, rem, dvd_sh;
  logic [N-2:0]  quo;
  logic [CW-1:0] cnt;
  logic          skip, hi_ovr;
  logic [N:0]    trial, diff;
  logic          q_bit;
  logic [N-1:0]  quo_nxt;

  // The high dividend half seeds the remainder; if it already reaches the
  // divisor the quotient cannot fit in N bits.
  assign trial   = {rem, dvd_sh[N-1]};
  assign diff    = trial - {1'b0, dvs};
  assign q_bit   = ~diff[N];
  assign quo_nxt = {quo, q_bit};
  assign done    = busy && (skip || cnt == CNT_END);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      skip     <= 1'b0;
      hi_ovr   <= 1'b0;
      dvs      <= '0;
      rem      <= '0;
      dvd_sh   <= '0;
      quo      <= '0;
      cnt      <= '0;
      quotient <= '0;
      ovr      <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      skip   <= divisor[N-1] || (divisor == '0);
      hi_ovr <= (DVD_HI >= divisor);
      dvs    <= divisor;
      rem    <= DVD_HI;
      dvd_sh <= DVD_LO;
      quo    <= '0;
      cnt    <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        if (skip || hi_ovr || quo_nxt[N-1]) begin
          quotient <= Q_MAX;
          ovr      <= 1'b1;
        end else begin
          quotient <= quo_nxt;
          ovr      <= 1'b0;
        end
      end else begin
        rem    <= q_bit ? diff[N-1:0] : trial[N-1:0];
        dvd_sh <= dvd_sh << 1;
        quo    <= quo_nxt[N-2:0];
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/symbol_scale_engine.sv
// Frame-based STBC/QO-STBC output stage: 1/Dh then NUM_SYM scaled symbols.
// Define SYM_SAT_EN to clamp overflowing symbols instead of wrapping.
module symbol_scale_engine
  import detector_pkg::*;
#(
  parameter int                 N        = DET_N,
  parameter int                 Q        = DET_Q,
  parameter int                 NUM_SYM  = 4,
  parameter logic [NUM_SYM-1:0] SEL_IMAG = NUM_SYM'(4'b1100),
  parameter logic [NUM_SYM-1:0] NEG_MASK = NUM_SYM'(4'b1100),
  localparam int                IDX_W    = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_dh,
  input  logic [N*NUM_SYM-1:0] in_trace_r,
  input  logic [N*NUM_SYM-1:0] in_trace_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_sym,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 out_ovr,
  output logic                 busy
);

  localparam logic [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

  state_t                    state;
  logic                      start_q;
  logic [N-1:0]              dh_q;
  logic [NUM_SYM-1:0][N-1:0] tr_q, ti_q, sel_w;
  logic                      div_busy, div_done, div_ovr;
  logic [N-1:0]              recip;

  recip_serial_div #(.N(N), .Q(Q)) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_q),
    .divisor  (dh_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (recip),
    .ovr      (div_ovr)
  );

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE) || div_busy;

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_sel
    assign sel_w[k] = SEL_IMAG[k] ? ti_q[k] : tr_q[k];
  end

  // Symbol datapath: computes whichever index is about to be registered.
  logic                  ld_en, ld_last, ld_neg;
  logic [IDX_W-1:0]      ld_idx;
  logic [N-1:0]          sel, s_n, s_wrap, sym_val;
  logic signed [2*N-1:0] prod;
  logic                  range_ovr, neg_ovr, sym_ovr;

  assign ld_idx  = (state == ST_FILL) ? '0 : out_idx + 1'b1;
  assign ld_last = (ld_idx == IDX_W'(NUM_SYM-1));
  assign ld_en   = (state == ST_FILL) ||
                   ((state == ST_STREAM) && out_ready && !out_last);
  assign sel     = sel_w[ld_idx];
  assign ld_neg  = NEG_MASK[ld_idx];

  assign prod      = $signed({{N{sel[N-1]}}, sel}) * $signed({{N{recip[N-1]}}, recip});
  assign s_n       = prod[N+Q-1:Q];
  assign range_ovr = sext_ovr(SEXT_W'(prod), N+Q-1, 2*N-1);
  assign neg_ovr   = ld_neg && (s_n == S_MIN);
  assign sym_ovr   = range_ovr || neg_ovr;
  assign s_wrap    = ld_neg ? (~s_n + 1'b1) : s_n;

`ifdef SYM_SAT_EN
  // Overflow direction is the product sign, flipped when the symbol is negated.
  always_comb begin
    sym_val = s_wrap;
    if (range_ovr)    sym_val = (prod[2*N-1] ^ ld_neg) ? S_MIN : S_MAX;
    else if (neg_ovr) sym_val = S_MAX;
  end
`else
  assign sym_val = s_wrap;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      dh_q      <= '0;
      tr_q      <= '0;
      ti_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          dh_q    <= in_dh;
          tr_q    <= in_trace_r;
          ti_q    <= in_trace_i;
          start_q <= 1'b1;
          state   <= ST_DIV;
        end
        ST_DIV: if (div_done) state <= ST_FILL;
        ST_FILL: begin
          out_valid <= 1'b1;
          state     <= ST_STREAM;
        end
        ST_STREAM: if (out_ready && out_last) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output registers only move on a load, so a stalled consumer sees them hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_sym  <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      out_ovr  <= 1'b0;
    end else if (ld_en) begin
      out_sym  <= sym_val;
      out_idx  <= ld_idx;
      out_last <= ld_last;
      out_ovr  <= sym_ovr || div_ovr;
    end
  end

endmodule
